// File: rtl/synth_pkg.sv
// Shared synthesizer constants and helpers used by the phase accumulator
// and by the waveform lookup stage that consumes its output stream.
package synth_pkg;

    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_PHASE_W    = 32;
    localparam int DEF_STEP_W     = 32;

    // Ceiling log2, used to size voice-index fields (n >= 2 expected).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_adder_carry.sv
// Combinational W-bit adder with carry-out; the single adder shared by
// every voice through the slot multiplexer.
module phase_adder_carry #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    // Carry-out marks the phase crossing one full cycle.
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/multi_voice_phase_accumulator.sv
// Time-multiplexed phase accumulator: one adder services one voice per
// enabled clock in round-robin order and emits a (voice, phase, wrap, sync)
// stream one cycle later.
module multi_voice_phase_accumulator
    import synth_pkg::*;
#(
    parameter  int NUM_VOICES = DEF_NUM_VOICES,
    parameter  int PHASE_W    = DEF_PHASE_W,
    parameter  int STEP_W     = DEF_STEP_W,
    localparam int VID_W      = clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [VID_W-1:0]      wr_voice,
    input  logic [STEP_W-1:0]     wr_step,
    input  logic [NUM_VOICES-1:0] sync_mask,
    output logic                  out_valid,
    output logic [VID_W-1:0]      out_voice,
    output logic [PHASE_W-1:0]    out_phase,
    output logic                  out_wrap,
    output logic                  out_sync
);

    logic [VID_W-1:0]      r_slot;
    logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
    logic [STEP_W-1:0]     r_step  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_sync_pend;

    logic                  r_out_valid;
    logic [VID_W-1:0]      r_out_voice;
    logic [PHASE_W-1:0]    r_out_phase;
    logic                  r_out_wrap;
    logic                  r_out_sync;

    logic [PHASE_W-1:0]    w_cur_phase;
    logic [PHASE_W-1:0]    w_cur_step;
    logic [PHASE_W-1:0]    w_sum;
    logic                  w_carry;
    logic                  w_sync;
    logic [PHASE_W-1:0]    w_new_phase;
    logic                  w_new_wrap;
    logic                  w_last_slot;
    logic                  w_wr_ok;

    // Slot multiplexer: select the serviced voice's phase and zero-extended step.
    assign w_cur_phase = r_phase[r_slot];
    assign w_cur_step  = PHASE_W'(r_step[r_slot]);

    // A pending request or a same-cycle pulse both force this voice to zero.
    assign w_sync      = r_sync_pend[r_slot] | sync_mask[r_slot];
    assign w_new_phase = w_sync ? '0 : w_sum;
    assign w_new_wrap  = w_sync ? 1'b0 : w_carry;

    assign w_last_slot = (int'(r_slot) == NUM_VOICES - 1);
    assign w_wr_ok     = wr_en && (int'(wr_voice) < NUM_VOICES);

    phase_adder_carry #(
        .W (PHASE_W)
    ) u_adder (
        .i_a     (w_cur_phase),
        .i_b     (w_cur_step),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Round-robin slot counter, advancing only on enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= '0;
        end else if (en) begin
            r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
        end
    end

    // Phase storage: only the serviced voice is rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                r_phase[k] <= '0;
            end
        end else if (en) begin
            r_phase[r_slot] <= w_new_phase;
        end
    end

    // Step storage: the adder already read the old step, so a same-slot write lands next round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                r_step[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_step[wr_voice] <= wr_step;
        end
    end

    // Hard-sync requests: serviced voice consumes its request, others latch and merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_pend <= '0;
        end else begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                if (en && (k == int'(r_slot))) begin
                    r_sync_pend[k] <= 1'b0;
                end else if (sync_mask[k]) begin
                    r_sync_pend[k] <= 1'b1;
                end
            end
        end
    end

    // Output stage: one cycle behind the service; fields hold while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_voice <= '0;
            r_out_phase <= '0;
            r_out_wrap  <= 1'b0;
            r_out_sync  <= 1'b0;
        end else begin
            r_out_valid <= en;
            if (en) begin
                r_out_voice <= r_slot;
                r_out_phase <= w_new_phase;
                r_out_wrap  <= w_new_wrap;
                r_out_sync  <= w_sync;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_voice = r_out_voice;
    assign out_phase = r_out_phase;
    assign out_wrap  = r_out_wrap;
    assign out_sync  = r_out_sync;

endmodule

// File: tb/tb_multi_voice_phase_accumulator.sv
// Self-checking bench for multi_voice_phase_accumulator: vector table,
// directed corner sequences and randomized traffic against a voice-level model.
module tb_multi_voice_phase_accumulator;

    localparam int NV  = 8;
    localparam int PW  = 32;
    localparam int SW  = 32;
    localparam int VW  = 3;
    localparam int NV5 = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, wr_en;
    logic [VW-1:0] wr_voice;
    logic [SW-1:0] wr_step;
    logic [NV-1:0] sync_mask;
    logic          out_valid, out_wrap, out_sync;
    logic [VW-1:0] out_voice;
    logic [PW-1:0] out_phase;

    // Second instance with a non-power-of-two voice count, to reach out-of-range writes.
    logic           en5, wr_en5;
    logic [2:0]     wr_voice5;
    logic [SW-1:0]  wr_step5;
    logic [NV5-1:0] sync_mask5;
    logic           out_valid5, out_wrap5, out_sync5;
    logic [2:0]     out_voice5;
    logic [PW-1:0]  out_phase5;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_voice_phase_accumulator #(.NUM_VOICES(NV), .PHASE_W(PW), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_voice(wr_voice),
        .wr_step(wr_step), .sync_mask(sync_mask), .out_valid(out_valid),
        .out_voice(out_voice), .out_phase(out_phase), .out_wrap(out_wrap), .out_sync(out_sync)
    );

    multi_voice_phase_accumulator #(.NUM_VOICES(NV5), .PHASE_W(PW), .STEP_W(SW)) dut5 (
        .clk(clk), .reset(reset), .en(en5), .wr_en(wr_en5), .wr_voice(wr_voice5),
        .wr_step(wr_step5), .sync_mask(sync_mask5), .out_valid(out_valid5),
        .out_voice(out_voice5), .out_phase(out_phase5), .out_wrap(out_wrap5), .out_sync(out_sync5)
    );

    // Behavioural model state: per-voice phase, step, pending sync, and the next voice to serve.
    longint m_phase [NV];
    longint m_step  [NV];
    bit     m_pend  [NV];
    int     m_slot;
    bit     e_valid, e_wrap, e_sync;
    int     e_voice;
    longint e_phase;

    localparam longint CYCLE = 64'h1_0000_0000;

    typedef struct {
        bit          en;
        bit          wr_en;
        logic [2:0]  wv;
        logic [31:0] ws;
        logic [7:0]  mask;
        bit          ev;
        int          evoice;
        logic [31:0] ephase;
        bit          ewrap;
        bit          esync;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(bit e, bit we, logic [2:0] wv, logic [31:0] ws, logic [7:0] m,
                                bit ev, int evc, logic [31:0] eph, bit ew, bit es);
        vec_t r;
        r.en = e; r.wr_en = we; r.wv = wv; r.ws = ws; r.mask = m;
        r.ev = ev; r.evoice = evc; r.ephase = eph; r.ewrap = ew; r.esync = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NV; k++) begin
            m_phase[k] = 0; m_step[k] = 0; m_pend[k] = 0;
        end
        m_slot = 0;
        e_valid = 0; e_voice = 0; e_phase = 0; e_wrap = 0; e_sync = 0;
    endtask

    // One clock of the voice-level rules applied to the currently driven inputs.
    task automatic model_step();
        int     served;
        longint t;
        bit     s;
        served = -1;
        if (en) begin
            served = m_slot;
            s = m_pend[served] | sync_mask[served];
            if (s) begin
                m_phase[served] = 0;
                e_wrap = 0;
            end else begin
                t = m_phase[served] + m_step[served];
                e_wrap = (t >= CYCLE);
                m_phase[served] = t % CYCLE;
            end
            m_pend[served] = 0;
            e_valid = 1; e_voice = served; e_phase = m_phase[served]; e_sync = s;
            m_slot = (m_slot + 1) % NV;
        end else begin
            e_valid = 0;
        end
        for (int k = 0; k < NV; k++) begin
            if (k != served && sync_mask[k]) m_pend[k] = 1;
        end
        if (wr_en && int'(wr_voice) < NV) m_step[wr_voice] = longint'(wr_step);
    endtask

    // Advance one clock, compare every output with the model, drop one-cycle strobes.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", out_valid, e_valid);
        chk("voice", out_voice, e_voice);
        chk("phase", out_phase, e_phase);
        chk("wrap",  out_wrap,  e_wrap);
        chk("sync",  out_sync,  e_sync);
        wr_en = 0;
        sync_mask = '0;
    endtask

    task automatic write_step(input int v, input logic [31:0] s);
        bit save_en;
        save_en = en;
        en = 0; wr_en = 1; wr_voice = v[2:0]; wr_step = s;
        tick();
        en = save_en;
    endtask

    task automatic run_to_slot(input int s);
        for (int g = 0; g < NV && m_slot != s; g++) tick();
    endtask

    task automatic run_to_output(input int v);
        tick();
        for (int g = 0; g < NV && !(e_valid && e_voice == v); g++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint p0;
        int     n3;

        reset = 1; en = 0; wr_en = 0; wr_voice = '0; wr_step = '0; sync_mask = '0;
        en5 = 0; wr_en5 = 0; wr_voice5 = '0; wr_step5 = '0; sync_mask5 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", out_valid, 0);
        chk("rst voice", out_voice, 0);
        chk("rst phase", out_phase, 0);
        chk("rst wrap",  out_wrap,  0);
        chk("rst sync",  out_sync,  0);
        reset = 0;

        // Vector table: voice 0 stepping by 0xC000_0000 across three rounds.
        tbl[0] = mk(0, 1, 3'd0, 32'hC000_0000, 8'h00, 0, 0, 32'h0, 0, 0);
        for (int i = 1; i < 18; i++) begin
            tbl[i] = mk(1, 0, 3'd0, 32'h0, 8'h00, 1, (i - 1) % NV, 32'h0, 0, 0);
        end
        tbl[1].ephase  = 32'hC000_0000;
        tbl[9].ephase  = 32'h8000_0000; tbl[9].ewrap  = 1;
        tbl[17].ephase = 32'h4000_0000; tbl[17].ewrap = 1;
        for (int i = 0; i < 18; i++) begin
            en = tbl[i].en; wr_en = tbl[i].wr_en; wr_voice = tbl[i].wv;
            wr_step = tbl[i].ws; sync_mask = tbl[i].mask;
            tick();
            chk("tbl valid", out_valid, tbl[i].ev);
            chk("tbl voice", out_voice, tbl[i].evoice);
            chk("tbl phase", out_phase, tbl[i].ephase);
            chk("tbl wrap",  out_wrap,  tbl[i].ewrap);
            chk("tbl sync",  out_sync,  tbl[i].esync);
        end

        // Basic accumulate on voice 3: k-th update is k * 0x1000_0000, 16th wraps to zero.
        write_step(3, 32'h1000_0000);
        en = 1;
        n3 = 0;
        for (int c = 0; c < 16 * NV + NV; c++) begin
            tick();
            if (out_valid && out_voice == 3 && n3 < 16) begin
                n3++;
                chk("acc phase", out_phase, (longint'(n3) * 64'h1000_0000) % CYCLE);
                chk("acc wrap",  out_wrap,  n3 == 16);
            end
        end
        chk("acc count", n3, 16);

        // Hard sync requested while another voice is serviced, then same-slot request.
        write_step(2, 32'h0123_4567);
        en = 1;
        run_to_slot(6);
        sync_mask = 8'h04;
        run_to_output(2);
        chk("sync phase", out_phase, 0);
        chk("sync flag",  out_sync,  1);
        chk("sync wrap",  out_wrap,  0);
        run_to_output(2);
        chk("post sync phase", out_phase, 32'h0123_4567);
        chk("post sync flag",  out_sync,  0);
        run_to_slot(2);
        sync_mask = 8'h04;
        tick();
        chk("same sync voice", out_voice, 2);
        chk("same sync phase", out_phase, 0);
        chk("same sync flag",  out_sync,  1);

        // Step write colliding with the serviced voice uses the old step first.
        write_step(5, 32'd100);
        en = 1;
        run_to_slot(5);
        p0 = m_phase[5];
        wr_en = 1; wr_voice = 3'd5; wr_step = 32'd1;
        tick();
        chk("coll voice", out_voice, 5);
        chk("coll old",   out_phase, (p0 + 100) % CYCLE);
        run_to_output(5);
        chk("coll new",   out_phase, (p0 + 101) % CYCLE);

        // Enable gating at slot 4: three idle cycles, then voice 4 resumes.
        run_to_slot(4);
        en = 0;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("gate valid", out_valid, 0);
        end
        en = 1;
        tick();
        chk("resume voice", out_voice, 4);

        // Randomized traffic including zero and all-ones steps.
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 4) == 0) begin
                wr_en = 1;
                wr_voice = 3'($urandom_range(0, NV - 1));
                case ($urandom_range(0, 3))
                    0: wr_step = 32'h0;
                    1: wr_step = 32'hFFFF_FFFF;
                    default: wr_step = $urandom;
                endcase
            end
            if ($urandom_range(0, 5) == 0) sync_mask = 8'($urandom);
            tick();
        end

        // Mid-stream reset with every step nonzero: outputs clear without waiting for a clock.
        en = 1;
        for (int k = 0; k < NV; k++) write_step(k, 32'h0100_0000 * (k + 1));
        en = 1;
        repeat (10) tick();
        #3;
        reset = 1;
        #1;
        chk("mid rst valid", out_valid, 0);
        chk("mid rst voice", out_voice, 0);
        chk("mid rst phase", out_phase, 0);
        chk("mid rst wrap",  out_wrap,  0);
        chk("mid rst sync",  out_sync,  0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        en = 1;
        tick();
        chk("after rst voice", out_voice, 0);
        chk("after rst phase", out_phase, 0);
        tick();
        chk("after rst v1 phase", out_phase, 0);

        // Five-voice instance: out-of-range writes ignored, slot wraps after voice 4.
        en = 0;
        wr_en5 = 1; wr_voice5 = 3'd6; wr_step5 = 32'h1234_5678;
        @(posedge clk); #1;
        wr_voice5 = 3'd7;
        @(posedge clk); #1;
        wr_en5 = 0; en5 = 1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("v5 valid", out_valid5, 1);
            chk("v5 voice", out_voice5, c % NV5);
            chk("v5 phase", out_phase5, 0);
        end
        en5 = 0; wr_en5 = 1; wr_voice5 = 3'd1; wr_step5 = 32'd7;
        @(posedge clk); #1;
        wr_en5 = 0; en5 = 1;
        @(posedge clk); #1;
        chk("v5 voice0", out_voice5, 0);
        @(posedge clk); #1;
        chk("v5 voice1", out_voice5, 1);
        chk("v5 phase1", out_phase5, 7);
        en5 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
